// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM slot scheduler.
//   TDM_NUM_CH / TDM_SEL_W / TDM_CNT_W : default channel count, select width,
//                                        idle-counter width
//   state_e : scheduler run state
//   mode_e  : slot policy (fixed TDM or work-conserving skip-empty)
package tdm_pkg;

  localparam int TDM_NUM_CH = 4;
  localparam int TDM_SEL_W  = $clog2(TDM_NUM_CH);
  localparam int TDM_CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    FIXED = 1'b0,
    SKIP  = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_next_ptr.sv
// Combinational round-robin finder: returns the first eligible index strictly
// after ptr_i, wrapping around; ptr_i itself is only returned when it is the
// sole eligible index.
//   ptr_i   : current pointer
//   elig_i  : per-index eligible vector
//   next_o  : next eligible index (ptr_i when none found)
//   found_o : at least one index is eligible
module rr_next_ptr
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic [NUM_CH-1:0] elig_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit wins. Offset
  // NUM_CH truncates to zero, which places ptr_i itself last in priority.
  always_comb begin
    next_o  = ptr_i;
    found_o = 1'b0;
    cand    = ptr_i;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (elig_i[cand]) begin
        next_o  = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// TDM slot scheduler: picks one queue per cycle, strobes its read line and
// drives the mux select, in fixed-TDM or skip-empty round-robin mode.
//   clk, reset         : clock, synchronous active-high reset
//   en                 : run enable
//   mode               : 0 fixed TDM, 1 skip-empty
//   slot_mask, empty   : per-channel slot enable and queue-empty flags
//   sel, read          : issued slot index and its one-hot read strobe
//   valid, data_sel    : read and sel delayed one cycle (mux output alignment)
//   frame_start        : one-cycle pulse at the start of each frame
//   idle_cnt           : saturating count of slots issued without a read
//
// state | meaning
// IDLE  | no slots issued; read/frame_start low, sel and idle_cnt held
// RUN   | one slot decision per cycle while en stays high
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int CNT_W  = TDM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [NUM_CH-1:0] slot_mask,
  input  logic [NUM_CH-1:0] empty,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] read,
  output logic              valid,
  output logic [SEL_W-1:0]  data_sel,
  output logic              frame_start,
  output logic [CNT_W-1:0]  idle_cnt
);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q, data_sel_q;
  logic [NUM_CH-1:0] read_q;
  logic              valid_q, frame_start_q;
  logic [CNT_W-1:0]  idle_cnt_q;

  logic [NUM_CH-1:0] elig;
  logic [SEL_W-1:0]  rr_next;
  logic              rr_found;

  logic [SEL_W-1:0]  slot_sel_d;
  logic              slot_hit_d;
  logic              slot_fs_d;
  logic [NUM_CH-1:0] read_d;
  logic [CNT_W-1:0]  idle_cnt_d;

  assign elig = slot_mask & ~empty;

  rr_next_ptr #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_next_ptr (
    .ptr_i   (sel_q),
    .elig_i  (elig),
    .next_o  (rr_next),
    .found_o (rr_found)
  );

  // Slot decision for the coming edge, assuming en is high.
  always_comb begin
    slot_sel_d = sel_q;
    slot_hit_d = 1'b0;
    slot_fs_d  = 1'b0;
    if (state_q == IDLE) begin
      // A fresh run always opens a frame on channel 0, in either mode.
      slot_sel_d = '0;
      slot_hit_d = elig[0];
      slot_fs_d  = 1'b1;
    end else if (mode_e'(mode) == FIXED) begin
      slot_sel_d = sel_q + SEL_W'(1);
      slot_hit_d = elig[slot_sel_d];
      slot_fs_d  = (slot_sel_d == '0);
    end else if (rr_found) begin
      slot_sel_d = rr_next;
      slot_hit_d = 1'b1;
      slot_fs_d  = (rr_next <= sel_q);
    end
  end

  assign read_d     = slot_hit_d ? (NUM_CH'(1) << slot_sel_d) : '0;
  assign idle_cnt_d = slot_hit_d ? idle_cnt_q
                    : ((idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      read_q        <= '0;
      valid_q       <= 1'b0;
      data_sel_q    <= '0;
      frame_start_q <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      valid_q    <= |read_q;
      data_sel_q <= sel_q;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q       <= RUN;
            sel_q         <= slot_sel_d;
            read_q        <= read_d;
            frame_start_q <= slot_fs_d;
            idle_cnt_q    <= idle_cnt_d;
          end else begin
            read_q        <= '0;
            frame_start_q <= 1'b0;
          end
        end
        RUN: begin
          if (en) begin
            sel_q         <= slot_sel_d;
            read_q        <= read_d;
            frame_start_q <= slot_fs_d;
            idle_cnt_q    <= idle_cnt_d;
          end else begin
            state_q       <= IDLE;
            read_q        <= '0;
            frame_start_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign read        = read_q;
  assign valid       = valid_q;
  assign data_sel    = data_sel_q;
  assign frame_start = frame_start_q;
  assign idle_cnt    = idle_cnt_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
module tb_tdm_slot_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, en, mode;
  logic [3:0] slot_mask, empty;
  logic [1:0] sel, data_sel;
  logic [3:0] read;
  logic       valid, frame_start;
  logic [7:0] idle_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state, derived from the scheduling rules.
  bit      m_run;
  int      m_sel, m_read, m_valid, m_dsel, m_fs, m_idle;

  typedef struct {
    bit       rst, en, mode;
    bit [3:0] mask, empty;
    bit [1:0] sel;
    bit [3:0] read;
    bit       valid;
    bit [1:0] dsel;
    bit       fs;
    bit [7:0] idle;
  } vec_t;

  vec_t tbl[$];

  tdm_slot_scheduler #(.NUM_CH(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .slot_mask   (slot_mask),
    .empty       (empty),
    .sel         (sel),
    .read        (read),
    .valid       (valid),
    .data_sel    (data_sel),
    .frame_start (frame_start),
    .idle_cnt    (idle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pack_out(int s, int r, int v, int d, int f, int i);
    return {s[1:0], r[3:0], v[0], d[1:0], f[0], i[7:0]};
  endfunction

  function automatic logic [17:0] dut_out();
    return {sel, read, valid, data_sel, frame_start, idle_cnt};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    int elig, nsel, hit, fs, c;
    if (reset) begin
      m_run = 0; m_sel = 0; m_read = 0; m_valid = 0; m_dsel = 0; m_fs = 0; m_idle = 0;
      return;
    end
    m_valid = (m_read != 0) ? 1 : 0;
    m_dsel  = m_sel;
    if (!en) begin
      m_run = 0; m_read = 0; m_fs = 0;
      return;
    end
    elig = int'(slot_mask & ~empty);
    nsel = m_sel; hit = 0; fs = 0;
    if (!m_run) begin
      nsel = 0; hit = elig & 1; fs = 1;
    end else if (mode == 1'b0) begin
      nsel = (m_sel + 1) % N;
      hit  = (elig >> nsel) & 1;
      fs   = (nsel == 0);
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_sel + k) % N;
        if (!hit && ((elig >> c) & 1)) begin
          hit = 1; nsel = c; fs = (c <= m_sel);
        end
      end
    end
    m_sel  = nsel;
    m_read = hit ? (1 << nsel) : 0;
    m_fs   = fs;
    if (!hit && m_idle < 255) m_idle++;
    m_run = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", 32'(dut_out()), 32'(pack_out(m_sel, m_read, m_valid, m_dsel, m_fs, m_idle)));
  endtask

  task automatic drive(bit r, bit e, bit md, bit [3:0] mk, bit [3:0] em);
    reset = r; en = e; mode = md; slot_mask = mk; empty = em;
  endtask

  task automatic add(bit r, bit e, bit md, bit [3:0] mk, bit [3:0] em,
                     bit [1:0] s, bit [3:0] rd, bit v, bit [1:0] d, bit f, bit [7:0] i);
    vec_t x;
    x.rst = r; x.en = e; x.mode = md; x.mask = mk; x.empty = em;
    x.sel = s; x.read = rd; x.valid = v; x.dsel = d; x.fs = f; x.idle = i;
    tbl.push_back(x);
  endtask

  initial begin
    drive(1, 0, 0, 4'hF, 4'h0);

    //   rst en md mask  empty   sel read  v dsel fs idle
    add(1, 0, 0, 4'hF, 4'h0,   0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 0, 4'hF, 4'h0,   0, 4'h1, 0, 0, 1, 0);
    add(0, 1, 0, 4'hF, 4'h0,   1, 4'h2, 1, 0, 0, 0);
    add(0, 1, 0, 4'hF, 4'h0,   2, 4'h4, 1, 1, 0, 0);
    add(0, 1, 0, 4'hF, 4'h0,   3, 4'h8, 1, 2, 0, 0);
    add(0, 1, 0, 4'hF, 4'h0,   0, 4'h1, 1, 3, 1, 0);
    add(0, 1, 0, 4'hF, 4'h4,   1, 4'h2, 1, 0, 0, 0);
    add(0, 1, 0, 4'hF, 4'h4,   2, 4'h0, 1, 1, 0, 1);
    add(0, 1, 0, 4'hF, 4'h4,   3, 4'h8, 0, 2, 0, 1);
    add(0, 1, 0, 4'hF, 4'h4,   0, 4'h1, 1, 3, 1, 1);
    add(0, 0, 0, 4'hF, 4'h4,   0, 4'h0, 1, 0, 0, 1);
    add(0, 0, 0, 4'hF, 4'h4,   0, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'hF, 4'hA,   0, 4'h1, 0, 0, 1, 1);
    add(0, 1, 1, 4'hF, 4'hA,   2, 4'h4, 1, 0, 0, 1);
    add(0, 1, 1, 4'hF, 4'hA,   0, 4'h1, 1, 2, 1, 1);
    add(0, 1, 1, 4'h0, 4'hA,   0, 4'h0, 1, 0, 0, 2);
    add(1, 1, 1, 4'hF, 4'h0,   0, 4'h0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].mask, tbl[i].empty);
      tick();
      check($sformatf("table[%0d]", i), 32'(dut_out()),
            32'({tbl[i].sel, tbl[i].read, tbl[i].valid, tbl[i].dsel, tbl[i].fs, tbl[i].idle}));
    end

    // Skip mode: lone eligible channel 2, then everything empty long enough
    // to saturate the idle counter while sel stays parked.
    drive(1, 0, 1, 4'hF, 4'h0); tick();
    drive(0, 1, 1, 4'hF, 4'hB); tick(); tick(); tick();
    check("skip_sole_sel", 32'(sel), 32'd2);
    check("skip_sole_read", 32'(read), 32'h4);
    drive(0, 1, 1, 4'hF, 4'hF);
    for (int i = 0; i < 300; i++) tick();
    check("sat_idle", 32'(idle_cnt), 32'd255);
    check("sat_sel_hold", 32'(sel), 32'd2);
    check("sat_read", 32'(read), 32'd0);

    // Reset in the middle of a run while channel 2 is being read.
    drive(1, 0, 0, 4'hF, 4'h0); tick();
    drive(0, 1, 0, 4'hF, 4'h0); tick(); tick(); tick();
    check("pre_rst_read", 32'(read), 32'h4);
    drive(1, 1, 0, 4'hF, 4'h0); tick();
    check("mid_rst_outs", 32'(dut_out()), 32'd0);
    drive(0, 1, 0, 4'hF, 4'h0); tick();
    check("post_rst_sel", 32'(sel), 32'd0);
    check("post_rst_fs", 32'(frame_start), 32'd1);
    check("post_rst_valid", 32'(valid), 32'd0);

    // en dropped for three cycles at sel=1, then resumed.
    tick();
    check("pause_at_sel1", 32'(sel), 32'd1);
    drive(0, 0, 0, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_hold", 32'({sel, read, frame_start}), 32'({2'd1, 4'h0, 1'b0}));
    end
    drive(0, 1, 0, 4'hF, 4'h0); tick();
    check("resume", 32'({sel, read, frame_start}), 32'({2'd0, 4'h1, 1'b1}));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      slot_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      empty     = 4'($urandom) & 4'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
